spi_flash_word_reader: RTL and testbench

SPI flash word-fetch engine that sits directly upstream of `dma`, producing the `SPIFlash_rdata` / `rbusy` pair that `dma` forwards to the instruction register. On a read strobe it issues a standard READ (0x03) command plus 24-bit address to the serial flash, shifts in four bytes, and presents them as one little-endian 32-bit word. It owns the `flashClk`, `flashCs`, `flashMosi` and `flashMiso` pins.

---
 rtl/spi_flash_word_reader.sv | 126 ++++++++++++
 tb/tb_spi_flash_word_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_word_reader.sv
// SPI flash word fetcher: issues READ (0x03) + 24-bit address, shifts in
// four bytes and presents them as one little-endian 32-bit word.
// SCK is mode 0 (idles low); each SCK phase lasts CLK_DIV clk cycles.
module spi_flash_word_reader #(
   parameter int CLK_DIV = 1,
   parameter int CS_GAP  = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rstrb,
   input  logic [31:0] raddr,
   output logic [31:0] rdata,
   output logic        rbusy,
   output logic        flashClk,
   output logic        flashCs,
   output logic        flashMosi,
   input  logic        flashMiso
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam int GW = $clog2(CS_GAP) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [5:0]    bit_q, bit_d;
   logic [31:0]   tx_q, tx_d;
   logic [31:0]   rx_q, rx_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          sck_q, sck_d;
   logic          cs_q, cs_d;

   // State register and datapath registers; reset terminates any command
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         div_q   <= '0;
         gap_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
      end
   end

   // Next-state: SCK toggles every CLK_DIV cycles; rise samples MISO,
   // fall shifts TX and advances the bit counter
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      gap_d   = gap_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      unique case (state_q)
         IDLE: begin
            cs_d  = 1'b1;
            sck_d = 1'b0;
            if (rstrb) begin
               tx_d    = {8'h03, raddr[23:2], 2'b00};
               rx_d    = '0;
               bit_d   = '0;
               div_d   = '0;
               cs_d    = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[30:0], flashMiso};
               end else begin
                  // TX empties to zero after 32 shifts, so MOSI idles low
                  // through the data phase and afterwards
                  tx_d = {tx_q[30:0], 1'b0};
                  if (bit_q == 6'd63) begin
                     // First byte received sits in RX[31:24]; swap so it
                     // lands in bits [7:0]
                     rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                     cs_d    = 1'b1;
                     gap_d   = '0;
                     state_d = GAP;
                  end else begin
                     bit_d = bit_q + 6'd1;
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign rdata     = rdata_q;
   assign rbusy     = (state_q != IDLE);
   assign flashClk  = sck_q;
   assign flashCs   = cs_q;
   assign flashMosi = tx_q[31];

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Bench: two readers (CLK_DIV=1/CS_GAP=2 and CLK_DIV=4/CS_GAP=3), each
// talking to a behavioural serial flash; results compared to a word model.
module tb_spi_flash_word_reader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  rstrb = '0;
   logic [1:0]  rbusy, sck, cs, mosi, miso;
   logic [31:0] raddr [2];
   logic [31:0] rdata [2];
   logic [31:0] cmd_w [2];
   int          nb_w  [2];
   logic [31:0] prev_rd [2];
   logic [7:0]  salt;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   // Flash contents: fixed bytes 11 22 33 44 at 0x10, hashed elsewhere
   function automatic logic [7:0] fbyte(input logic [23:0] a);
      logic [7:0] m;
      if (a >= 24'h10 && a <= 24'h13) begin
         m = a[7:0] - 8'h0F;
         return 8'h11 * m;
      end
      return salt ^ a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5A;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DIV = (g == 0) ? 1 : 4;
      localparam int GP  = (g == 0) ? 2 : 3;
      int          nb  = 0;
      logic [31:0] cmd = '0;
      logic        so  = 1'b0;

      spi_flash_word_reader #(.CLK_DIV(DIV), .CS_GAP(GP)) u_dut (
         .clk(clk), .resetn(resetn), .rstrb(rstrb[g]), .raddr(raddr[g]),
         .rdata(rdata[g]), .rbusy(rbusy[g]), .flashClk(sck[g]),
         .flashCs(cs[g]), .flashMosi(mosi[g]), .flashMiso(miso[g]));

      assign miso[g]  = so;
      assign cmd_w[g] = cmd;
      assign nb_w[g]  = nb;

      // CS fall starts a new command; SCK rise captures command bits
      always @(negedge cs[g] or posedge sck[g]) begin
         if (!sck[g]) begin
            nb  = 0;
            cmd = '0;
         end else if (!cs[g]) begin
            if (nb < 32) cmd = {cmd[30:0], mosi[g]};
            nb++;
         end
      end

      // Data bits are driven MSB first on SCK fall, byte address ascending
      always @(negedge sck[g]) begin : drv
         int k;
         logic [7:0] b;
         if (!cs[g] && nb >= 32 && nb < 64) begin
            k  = nb - 32;
            b  = fbyte(cmd[23:0] + 24'(k / 8));
            so = b[7 - (k % 8)];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One read on instance g; optional busy-time request and reset abort
   task automatic run_read(input int g, input logic [31:0] addr, input int ghost,
                           input int abort_at, input bit b2b);
      int div, gp, c, r1, r2, rises, cs_rise, done, lastchg, mviol, rviol;
      logic psck, pmosi;
      logic [23:0] a;
      logic [31:0] exp_w;
      div = (g == 0) ? 1 : 4;
      gp  = (g == 0) ? 2 : 3;
      a   = {addr[23:2], 2'b00};
      exp_w = {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
      if (!b2b) @(negedge clk);
      raddr[g] = addr;
      rstrb[g] = 1'b1;
      @(posedge clk);
      r1 = -1; r2 = -1; rises = 0; cs_rise = -1; done = -1;
      lastchg = 1; mviol = 0; rviol = 0; psck = 1'b0; pmosi = 1'b0;
      for (c = 1; c <= 1 + 128 * div + gp + 20; c++) begin
         @(negedge clk);
         rstrb[g] = (c == ghost);
         if (c == ghost) raddr[g] = addr ^ 32'h00AB_C0F0;
         if (c == 1) begin
            chk("start_busy", 32'(rbusy[g]), 32'd1);
            chk("start_cs",   32'(cs[g]),    32'd0);
            chk("start_mosi", 32'(mosi[g]),  32'd0);
            chk("start_sck",  32'(sck[g]),   32'd0);
         end
         if (mosi[g] !== pmosi) begin
            if (sck[g]) mviol++;
            lastchg = c;
         end
         if (sck[g] && !psck) begin
            rises++;
            if (c - lastchg < div) mviol++;
            if (r1 < 0) r1 = c;
            else if (r2 < 0) r2 = c;
         end
         if (!cs[g] && rdata[g] !== prev_rd[g]) rviol++;
         if (cs[g] && cs_rise < 0) cs_rise = c;
         psck  = sck[g];
         pmosi = mosi[g];
         if (c == abort_at) begin
            #2 resetn = 1'b0;
            #1;
            chk("abort_cs",    32'(cs[g]),    32'd1);
            chk("abort_sck",   32'(sck[g]),   32'd0);
            chk("abort_mosi",  32'(mosi[g]),  32'd0);
            chk("abort_busy",  32'(rbusy[g]), 32'd0);
            chk("abort_rdata", rdata[g],      32'd0);
            prev_rd[0] = '0;
            prev_rd[1] = '0;
            rstrb[g] = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            return;
         end
         if (!rbusy[g]) begin
            done = c;
            break;
         end
      end
      chk("done_cycle",  32'(done),    32'(1 + 128 * div + gp));
      chk("cs_rise",     32'(cs_rise), 32'(1 + 128 * div));
      chk("first_rise",  32'(r1),      32'(1 + div));
      chk("sck_period",  32'(r2 - r1), 32'(2 * div));
      chk("sck_rises",   32'(rises),   32'd64);
      chk("flash_rises", 32'(nb_w[g]), 32'd64);
      chk("mosi_cmd",    cmd_w[g],     {8'h03, a});
      chk("rdata",       rdata[g],     exp_w);
      chk("mode0_viol",  32'(mviol),   32'd0);
      chk("rdata_hold",  32'(rviol),   32'd0);
      prev_rd[g] = exp_w;
   endtask

   initial begin
      salt = 8'($urandom);
      raddr[0] = '0;
      raddr[1] = '0;
      prev_rd[0] = '0;
      prev_rd[1] = '0;

      // Reset with random inputs toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rstrb    = 2'($urandom);
         raddr[0] = $urandom;
         raddr[1] = $urandom;
      end
      for (int g = 0; g < 2; g++) begin
         chk("rst_cs",    32'(cs[g]),    32'd1);
         chk("rst_sck",   32'(sck[g]),   32'd0);
         chk("rst_mosi",  32'(mosi[g]),  32'd0);
         chk("rst_busy",  32'(rbusy[g]), 32'd0);
         chk("rst_rdata", rdata[g],      32'd0);
      end
      rstrb = '0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // Default read at 0x10
      run_read(0, 32'h0000_0010, -1, -1, 1'b0);
      chk("default_word", rdata[0], 32'h4433_2211);
      // Address masking, issued back-to-back
      run_read(0, 32'hFF12_3457, -1, -1, 1'b1);
      // Request while busy is ignored
      run_read(0, $urandom, 40, -1, 1'b1);
      // Reset mid-transfer, then a clean read at 0x20
      run_read(0, $urandom, -1, 60, 1'b0);
      run_read(0, 32'h0000_0020, -1, -1, 1'b0);

      // Slow divider
      run_read(1, 32'h0000_0010, -1, -1, 1'b0);
      chk("slow_word", rdata[1], 32'h4433_2211);
      run_read(1, $urandom, 100, -1, 1'b1);

      // Random reads on both instances
      for (int i = 0; i < 6; i++) begin
         run_read(i % 2, $urandom, -1, -1, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
